memory_instruction: RTL and testbench
=====================================

// Module: memory_instruction
// PURPOSE
//   Instruction memory for the 5-stage RV32 pipeline; sits in IF stage.
//   Combinational read: Address indexes the array directly, one 32-bit word per index.
//   Preloaded boot program; clocked program-load port; out-of-range detection.
// PARAMETERS
//   ADDR_WIDTH  32          width of Address / prog_addr
//   INST_WIDTH  32          instruction word width
//   IMEM_DEPTH  1024        number of array entries (valid indices 0..IMEM_DEPTH-1)
//   NOP_WORD    32'h00000013 fill/default word (addi x0,x0,0)
// PORTS
//   clk          in   1           clock; prog writes and sticky flag on rising edge
//   rst          in   1           reset, asynchronous, active-high
//   Address      in   ADDR_WIDTH  read index (PC), used unscaled as array index
//   instruction  out  INST_WIDTH  word at Address (combinational)
//   addr_err     out  1           Address >= IMEM_DEPTH (combinational)
//   prog_we      in   1           program-load write enable
//   prog_addr    in   ADDR_WIDTH  program-load index
//   prog_wdata   in   INST_WIDTH  program-load data
//   err_sticky   out  1           latched: any addr_err or bad prog write since reset
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   Initial contents: every entry = NOP_WORD, except
//     [0]=003100B3 [4]=00F00113 [8]=00700193 [12]=023160B3 [16]=00708213
//     [20]=002212B3 [24]=00208113 [28]=00808493 [32]=004120A3 [36]=00112303
//     [40]=00330293 [44]=00308393 [48]=00518413 [52]=00508513
//   Read: instruction = mem[Address] with zero latency; no clock involved.
//     Address >= IMEM_DEPTH -> instruction = NOP_WORD, addr_err = 1; else addr_err = 0.
//     No alignment check; odd indices are ordinary entries.
//   Write: on rising clk with rst=0 and prog_we=1: if prog_addr < IMEM_DEPTH,
//     mem[prog_addr] <= prog_wdata; else write dropped.
//     Read of same index shows new word immediately after the edge (no bypass before edge).
//   err_sticky: async cleared to 0 by rst; set at rising clk when addr_err=1, or when
//     prog_we=1 with prog_addr >= IMEM_DEPTH; stays 1 until next reset.
//   Reset: does not alter memory contents; writes ignored while rst=1.
//     Reset values: err_sticky=0; instruction/addr_err are combinational (no reset value).
//   Reset asserted mid-write cycle: that write is not performed.
// TESTING
//   Address 0,1,2 after power-up -> 003100B3, 00000013, 00000013; addr_err=0.
//   Sweep Address 0..52 step 4 -> the 14 preloaded words in table order.
//   prog_we=1, prog_addr=1, prog_wdata=DEADBEEF, one edge -> Address=1 reads DEADBEEF.
//   Address=1024 -> instruction=00000013, addr_err=1; next edge err_sticky=1.
//   prog write to index 2000 -> no entry changes, err_sticky=1 after edge.
//   err_sticky=1, assert rst between edges -> err_sticky=0 at once; contents unchanged.

Source files
------------

// File: rtl/memory_instruction.sv
// IF-stage instruction memory: zero-latency indexed read over a preloaded boot image,
// a clocked program-load port, and a sticky out-of-range error flag.
module memory_instruction #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter logic [INST_WIDTH-1:0] NOP_WORD = INST_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address,
  output logic [INST_WIDTH-1:0] instruction,
  output logic                  addr_err,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [INST_WIDTH-1:0] prog_wdata,
  output logic                  err_sticky
);

  localparam int unsigned IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(IMEM_DEPTH);

  typedef logic [INST_WIDTH-1:0] mem_t [IMEM_DEPTH];

  // Boot image is the power-up value of the array; reset never touches it.
  mem_t mem_q = '{
    0:  INST_WIDTH'(32'h003100B3),
    4:  INST_WIDTH'(32'h00F00113),
    8:  INST_WIDTH'(32'h00700193),
    12: INST_WIDTH'(32'h023160B3),
    16: INST_WIDTH'(32'h00708213),
    20: INST_WIDTH'(32'h002212B3),
    24: INST_WIDTH'(32'h00208113),
    28: INST_WIDTH'(32'h00808493),
    32: INST_WIDTH'(32'h004120A3),
    36: INST_WIDTH'(32'h00112303),
    40: INST_WIDTH'(32'h00330293),
    44: INST_WIDTH'(32'h00308393),
    48: INST_WIDTH'(32'h00518413),
    52: INST_WIDTH'(32'h00508513),
    default: NOP_WORD
  };

  logic prog_in_range;
  logic prog_bad;
  logic err_sticky_q;
  logic err_sticky_d;

  always_comb begin
    addr_err    = (Address >= DEPTH_A);
    instruction = NOP_WORD;
    if (!addr_err) begin
      instruction = mem_q[Address[IDX_W-1:0]];
    end
  end

  always_comb begin
    prog_in_range = (prog_addr < DEPTH_A);
    prog_bad      = prog_we && !prog_in_range;
    err_sticky_d  = err_sticky_q | addr_err | prog_bad;
    err_sticky    = err_sticky_q;
  end

  // Writes sampled while rst is high are dropped, including a reset landing mid-cycle.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && prog_in_range) begin
      mem_q[prog_addr[IDX_W-1:0]] <= prog_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

endmodule

// File: tb/tb_memory_instruction.sv
// Directed scoreboard bench for memory_instruction: stimulus queues expectations,
// a monitor pops and compares on every probe strobe.
module tb_memory_instruction;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] instruction;
  logic        addr_err;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic        err_sticky;

  memory_instruction #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .IMEM_DEPTH(1024),
    .NOP_WORD  (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Address    (Address),
    .instruction(instruction),
    .addr_err   (addr_err),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        err;
    logic        stk;
  } exp_t;

  exp_t        sb[$];
  logic        probe = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  bit          done  = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] boot [14] = '{
    32'h003100B3, 32'h00F00113, 32'h00700193, 32'h023160B3, 32'h00708213,
    32'h002212B3, 32'h00208113, 32'h00808493, 32'h004120A3, 32'h00112303,
    32'h00330293, 32'h00308393, 32'h00518413, 32'h00508513
  };

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  initial begin
    forever begin
      @(probe);
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL probe_without_expectation: no queued entry at t=%0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (instruction !== e.ins || addr_err !== e.err || err_sticky !== e.stk) begin
          n_bad++;
          $display("FAIL %s: Address=%h got ins=%h err=%b stk=%b, expected ins=%h err=%b stk=%b",
                   e.name, Address, instruction, addr_err, err_sticky, e.ins, e.err, e.stk);
        end
      end
    end
  end

  task automatic expect_out(input string name, input logic [31:0] ins,
                            input logic err, input logic stk);
    exp_t e;
    #1;
    e.name = name; e.ins = ins; e.err = err; e.stk = stk;
    sb.push_back(e);
    probe = ~probe;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; Address = '0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    expect_out("reset_addr0", 32'h003100B3, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    Address = 32'd1; expect_out("powerup_addr1", NOP, 1'b0, 1'b0);
    Address = 32'd2; expect_out("powerup_addr2", NOP, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < 14; i++) begin
      Address = 32'(i * 4);
      expect_out($sformatf("boot_sweep_%0d", i * 4), boot[i], 1'b0, 1'b0);
    end
    Address = 32'd1023; expect_out("last_index", NOP, 1'b0, 1'b0);

    // Program write to index 1: no bypass before the edge, new word after.
    prog_we = 1'b1; prog_addr = 32'd1; prog_wdata = 32'hDEADBEEF; Address = 32'd1;
    expect_out("write_before_edge", NOP, 1'b0, 1'b0);
    tick();
    prog_we = 1'b0;
    expect_out("write_after_edge", 32'hDEADBEEF, 1'b0, 1'b0);
    Address = 32'd0; expect_out("neighbour_0_intact", 32'h003100B3, 1'b0, 1'b0);
    Address = 32'd2; expect_out("neighbour_2_intact", NOP, 1'b0, 1'b0);

    // Out-of-range read: combinational error now, sticky after the edge.
    Address = 32'd1024; expect_out("oor_read", NOP, 1'b1, 1'b0);
    tick();
    expect_out("oor_read_sticky", NOP, 1'b1, 1'b1);
    Address = 32'hFFFF_FFFF; expect_out("oor_max", NOP, 1'b1, 1'b1);
    Address = 32'd1023; tick();
    expect_out("sticky_holds", NOP, 1'b0, 1'b1);

    // Async reset between edges; a write during reset must be dropped.
    #2 rst = 1'b1;
    Address = 32'd1; expect_out("async_clear", 32'hDEADBEEF, 1'b0, 1'b0);
    prog_we = 1'b1; prog_addr = 32'd3; prog_wdata = 32'h1234_5678;
    tick();
    prog_we = 1'b0; rst = 1'b0;
    Address = 32'd3; expect_out("write_in_reset_dropped", NOP, 1'b0, 1'b0);
    Address = 32'd4; expect_out("contents_kept_4", 32'h00F00113, 1'b0, 1'b0);

    // Out-of-range program write: dropped, sets sticky.
    prog_we = 1'b1; prog_addr = 32'd2000; prog_wdata = 32'hCAFE_BABE; Address = 32'd0;
    tick();
    prog_we = 1'b0;
    expect_out("bad_write_sticky", 32'h003100B3, 1'b0, 1'b1);
    Address = 32'd976; expect_out("bad_write_no_alias", NOP, 1'b0, 1'b1);
    Address = 32'd1;   expect_out("bad_write_keeps_1", 32'hDEADBEEF, 1'b0, 1'b1);

    for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    done = 1'b1;
    $finish;
  end

  initial begin
    #50000;
    if (!done) begin
      $display("FAIL watchdog: run did not finish by t=%0t", $time);
      $fatal(1);
    end
  end

endmodule
